// File: rtl/fwd_ctrl_pkg.sv
// Shared types and constants for the EX/MEM forwarding and load-use stall controller.
package fwd_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'd1;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The part of a pipeline entry that forwarding decisions look at.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
  } fwd_src_t;

  typedef struct packed {
    fwd_src_t src;
    logic     memread;
  } pipe_entry_t;

  localparam fwd_src_t    SRC_BUBBLE  = '0;
  localparam pipe_entry_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Compares one ID source register against the EX and MEM producers and picks the operand select.
module fwd_match
  import fwd_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  fwd_src_t         ex_i,
  input  fwd_src_t         mem_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             ex_hit_o
);

  logic mem_hit;

  // Register 0 never matches because a producer with dst 0 is never a hit.
  always_comb begin
    ex_hit_o = ex_i.valid  & ex_i.regwrite  & (ex_i.dst  != '0) & (ex_i.dst  == src_i);
    mem_hit  = mem_i.valid & mem_i.regwrite & (mem_i.dst != '0) & (mem_i.dst == src_i);
    sel_o    = SEL_RF;
    if (ex_hit_o) begin
      sel_o = SEL_MEM;
    end else if (mem_hit) begin
      sel_o = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Tracks EX/MEM producers, registers EX operand selects one cycle after ID,
// and raises a combinational load-use stall with a saturating stall counter.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // MEM keeps no load flag: only a load sitting in EX can create a hazard.
  pipe_entry_t      ex_q,  ex_d;
  fwd_src_t         mem_q, mem_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic             ex_hit_a, ex_hit_b;
  logic             stall_c;
  logic             ex_bubble;

  fwd_match u_match_a (
    .src_i    (id_rs),
    .ex_i     (ex_q.src),
    .mem_i    (mem_q),
    .sel_o    (fwd_a),
    .ex_hit_o (ex_hit_a)
  );

  fwd_match u_match_b (
    .src_i    (id_rt),
    .ex_i     (ex_q.src),
    .mem_i    (mem_q),
    .sel_o    (fwd_b),
    .ex_hit_o (ex_hit_b)
  );

  always_comb begin
    stall_c     = id_valid & ~flush & ex_q.memread & (ex_hit_a | ex_hit_b);
    ex_bubble   = stall_c | flush | ~id_valid;

    mem_d       = ex_q.src;
    ex_d        = PIPE_BUBBLE;
    sel_a_d     = SEL_RF;
    sel_b_d     = SEL_RF;
    stall_cnt_d = stall_cnt_q;

    if (!ex_bubble) begin
      ex_d.src.valid    = 1'b1;
      ex_d.src.dst      = id_dst;
      ex_d.src.regwrite = id_regwrite;
      ex_d.memread      = id_memread;
      sel_a_d           = fwd_a;
      sel_b_d           = fwd_b;
    end

    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= PIPE_BUBBLE;
      mem_q       <= SRC_BUBBLE;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sel_a     = sel_a_q;
  assign sel_b     = sel_b_q;
  assign stall     = stall_c;
  assign stall_cnt = stall_cnt_q;

endmodule
